// File: rtl/izhikevich_array.sv
// izhikevich_array: a bank of NEURONS Izhikevich neurons that share one fixed-point datapath.
// A single step request walks every neuron through LOAD -> CALC -> WRITE, in index order.
// It then pulses step_done and presents the spikes of that step as a bit vector.
// Optional refractory counters are compiled in when IZH_REFRACTORY_EN is defined.
module izhikevich_array #(
    parameter int N       = 32,
    parameter int Q       = 16,
    parameter int NEURONS = 8,
    parameter int IDX_W   = $clog2(NEURONS),
    parameter int REF_CYC = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step_valid,
    output logic                step_ready,
    input  logic                i_wr_en,
    input  logic [IDX_W-1:0]    i_wr_idx,
    input  logic signed [N-1:0] i_wr_data,
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    input  logic signed [N-1:0] c,
    input  logic signed [N-1:0] d,
    input  logic signed [N-1:0] v_th,
    input  logic signed [N-1:0] dt,
    input  logic signed [N-1:0] v_init,
    input  logic signed [N-1:0] w_init,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic signed [N-1:0] rd_voltage,
    output logic signed [N-1:0] rd_w,
    output logic [NEURONS-1:0]  spike_vec,
    output logic                step_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CALC  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // 0.04 is rounded to the nearest Q-format code; 5 and 140 are exact.
    localparam longint            K04_L     = ((longint'(4) <<< Q) + 50) / 100;
    localparam logic signed [N-1:0] K04     = N'(K04_L);
    localparam logic signed [N-1:0] K5      = N'(longint'(5) <<< Q);
    localparam logic signed [N-1:0] K140    = N'(longint'(140) <<< Q);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NEURONS - 1);
    localparam logic [IDX_W:0]    NEURONS_W = (IDX_W + 1)'(NEURONS);

    // Reject configurations the datapath was not built for.
    if (NEURONS < 2 || REF_CYC < 1) begin : g_bad_params
        $error("izhikevich_array: NEURONS must be >= 2 and REF_CYC >= 1");
    end

    // Fixed-point multiply: full-width signed product, arithmetic shift by Q, wrap to N bits.
    function automatic logic signed [N-1:0] mul(input logic signed [N-1:0] x,
                                                 input logic signed [N-1:0] y);
        logic signed [2*N-1:0] p;
        p = (2*N)'(x) * (2*N)'(y);
        return p[Q+N-1:Q];
    endfunction

    logic [2:0]            state;
    logic [IDX_W-1:0]      idx;
    logic signed [N-1:0]   v_mem [NEURONS];
    logic signed [N-1:0]   w_mem [NEURONS];
    logic signed [N-1:0]   i_mem [NEURONS];
    logic signed [N-1:0]   op_v, op_w, op_i;
    logic signed [N-1:0]   dv_r, dw_r;
    logic                  spike_r;
    logic signed [N-1:0]   v_sq, poly, dv_next, dw_next;
    logic                  in_ref;
    logic                  fire;

    assign step_ready = (state == S_IDLE);
    assign step_done  = (state == S_DONE);

    // Euler increments for the neuron held in the operand registers.
    always_comb begin
        v_sq    = mul(op_v, op_v);
        poly    = mul(K04, v_sq) + mul(K5, op_v) + K140 - op_w + op_i;
        dv_next = mul(dt, poly);
        dw_next = mul(dt, mul(a, mul(b, op_v) - op_w));
        fire    = spike_r && !in_ref;
    end

`ifdef IZH_REFRACTORY_EN
    localparam int REF_W = $clog2(REF_CYC + 1);

    logic [REF_W-1:0] ref_cnt [NEURONS];

    // Refractory countdown: armed by a spike, decremented on each later WRITE of that neuron.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NEURONS; k++) begin
                ref_cnt[k] <= '0;
            end
        end else if (state == S_WRITE) begin
            if (ref_cnt[idx] != '0) begin
                ref_cnt[idx] <= ref_cnt[idx] - REF_W'(1);
            end else if (spike_r) begin
                ref_cnt[idx] <= REF_W'(REF_CYC);
            end
        end
    end

    assign in_ref = (ref_cnt[idx] != '0);
`else
    assign in_ref = 1'b0;
`endif

    // Step sequencer: walks idx through every neuron and collects the spike flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            spike_vec <= '0;
            op_v      <= '0;
            op_w      <= '0;
            op_i      <= '0;
            dv_r      <= '0;
            dw_r      <= '0;
            spike_r   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (step_valid) begin
                        spike_vec <= '0;
                        idx       <= '0;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    op_v  <= v_mem[idx];
                    op_w  <= w_mem[idx];
                    op_i  <= i_mem[idx];
                    state <= S_CALC;
                end
                S_CALC: begin
                    dv_r    <= dv_next;
                    dw_r    <= dw_next;
                    spike_r <= (op_v >= v_th);
                    state   <= S_WRITE;
                end
                S_WRITE: begin
                    if (fire) begin
                        spike_vec[idx] <= 1'b1;
                    end
                    if (idx == LAST_IDX) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= S_LOAD;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Neuron state memories: reset loading, current writes and the WRITE-phase update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NEURONS; k++) begin
                v_mem[k] <= v_init;
                w_mem[k] <= w_init;
                i_mem[k] <= '0;
            end
        end else begin
            if (i_wr_en && ({1'b0, i_wr_idx} < NEURONS_W)) begin
                i_mem[i_wr_idx] <= i_wr_data;
            end
            if (state == S_WRITE) begin
                if (in_ref) begin
                    v_mem[idx] <= c;
                end else if (spike_r) begin
                    v_mem[idx] <= c;
                    w_mem[idx] <= op_w + d;
                end else begin
                    v_mem[idx] <= op_v + dv_r;
                    w_mem[idx] <= op_w + dw_r;
                end
            end
        end
    end

    // Registered read port; it samples the memories before this cycle's update lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_voltage <= '0;
            rd_w       <= '0;
        end else if ({1'b0, rd_idx} < NEURONS_W) begin
            rd_voltage <= v_mem[rd_idx];
            rd_w       <= w_mem[rd_idx];
        end else begin
            rd_voltage <= '0;
            rd_w       <= '0;
        end
    end

endmodule

// File: tb/tb_izhikevich_array.sv
// tb_izhikevich_array: scoreboard bench for izhikevich_array (8 neurons, Q16.16).
// Stimulus pushes expected step results and read results into queues.
// A negedge monitor pops them whenever step_done or a read response appears.
// The refractory scenario is compiled only when IZH_REFRACTORY_EN is defined.
module tb_izhikevich_array;

    localparam int N       = 32;
    localparam int Q       = 16;
    localparam int NEURONS = 8;
    localparam int IDX_W   = 3;

    typedef struct {
        logic [NEURONS-1:0] spikes;
        int                 done_cnt;
        string              tag;
    } step_exp_t;

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] w;
        string        tag;
    } rd_exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                step_valid = 1'b0;
    logic                step_ready;
    logic                i_wr_en = 1'b0;
    logic [IDX_W-1:0]    i_wr_idx = '0;
    logic signed [N-1:0] i_wr_data = '0;
    logic signed [N-1:0] a = '0, b = '0, c = '0, d = '0;
    logic signed [N-1:0] v_th = '0, dt = '0, v_init = '0, w_init = '0;
    logic [IDX_W-1:0]    rd_idx = '0;
    logic signed [N-1:0] rd_voltage, rd_w;
    logic [NEURONS-1:0]  spike_vec;
    logic                step_done;

    logic      rd_req = 1'b0;
    logic      rd_req_d = 1'b0;
    int        cycle_cnt = 0;
    int        checks = 0;
    int        errors = 0;
    step_exp_t step_q[$];
    rd_exp_t   rd_q[$];

    izhikevich_array #(
        .N(N), .Q(Q), .NEURONS(NEURONS), .IDX_W(IDX_W), .REF_CYC(2)
    ) dut (
        .clk(clk), .rst(rst),
        .step_valid(step_valid), .step_ready(step_ready),
        .i_wr_en(i_wr_en), .i_wr_idx(i_wr_idx), .i_wr_data(i_wr_data),
        .a(a), .b(b), .c(c), .d(d),
        .v_th(v_th), .dt(dt), .v_init(v_init), .w_init(w_init),
        .rd_idx(rd_idx), .rd_voltage(rd_voltage), .rd_w(rd_w),
        .spike_vec(spike_vec), .step_done(step_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle_cnt <= cycle_cnt + 1;
        rd_req_d  <= rd_req;
    end

    // Integer value in Q16.16.
    function automatic logic signed [N-1:0] fx(input int x);
        return N'(x * 65536);
    endfunction

    task automatic checkOutput(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: step results on step_done, read results one cycle after a read request.
    always @(negedge clk) begin
        step_exp_t se;
        rd_exp_t   re;
        if (step_done) begin
            if (step_q.size() == 0) begin
                checkOutput("unexpected_step_done", 32'd1, 32'd0);
            end else begin
                se = step_q.pop_front();
                checkOutput({se.tag, "_spikes"}, N'(spike_vec), N'(se.spikes));
                checkOutput({se.tag, "_done_cycle"}, N'(cycle_cnt), N'(se.done_cnt));
            end
        end
        if (rd_req_d) begin
            if (rd_q.size() == 0) begin
                checkOutput("unexpected_read", 32'd1, 32'd0);
            end else begin
                re = rd_q.pop_front();
                checkOutput({re.tag, "_v"}, rd_voltage, re.v);
                checkOutput({re.tag, "_w"}, rd_w, re.w);
            end
        end
    end

    // All tasks start and end at #1 after a rising edge.
    task automatic applyReset(input logic signed [N-1:0] vi, input logic signed [N-1:0] wi);
        rst        = 1'b1;
        step_valid = 1'b0;
        v_init     = vi;
        w_init     = wi;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic waitReady();
        int n = 0;
        while (!step_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!step_ready) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic applyStimulus(input logic [NEURONS-1:0] exp_spk, input string tag);
        step_exp_t e;
        waitReady();
        step_valid = 1'b1;
        e.spikes   = exp_spk;
        // step_done appears 3*NEURONS+1 cycles after the accept cycle (count taken after the accept edge)
        e.done_cnt = cycle_cnt + 1 + 3 * NEURONS;
        e.tag      = tag;
        step_q.push_back(e);
        @(posedge clk);
        #1;
        step_valid = 1'b0;
        waitReady();
    endtask

    task automatic writeCurrent(input int idx, input logic signed [N-1:0] val);
        i_wr_en   = 1'b1;
        i_wr_idx  = IDX_W'(idx);
        i_wr_data = val;
        @(posedge clk);
        #1;
        i_wr_en = 1'b0;
    endtask

    task automatic readNeuron(input int idx, input logic signed [N-1:0] ev,
                              input logic signed [N-1:0] ew, input string tag);
        rd_exp_t e;
        e.v   = ev;
        e.w   = ew;
        e.tag = tag;
        rd_q.push_back(e);
        rd_idx = IDX_W'(idx);
        rd_req = 1'b1;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
    endtask

    task automatic applyHeldSteps();
        step_exp_t e;
        int        base;
        int        bad = 0;
        waitReady();
        step_valid = 1'b1;
        base       = cycle_cnt + 1 + 3 * NEURONS;
        e.spikes   = '0;
        e.done_cnt = base;
        e.tag      = "held1";
        step_q.push_back(e);
        e.done_cnt = base + 3 * NEURONS + 2;
        e.tag      = "held2";
        step_q.push_back(e);
        @(posedge clk);
        for (int k = 0; k <= 3 * NEURONS; k++) begin
            @(negedge clk);
            if (step_ready) bad++;
        end
        checkOutput("ready_low_busy", N'(bad), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        step_valid = 1'b0;
        waitReady();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Scenario 1: dt=0 freezes all state; reset values and step latency.
        a    = 32'sd1311;
        b    = 32'sd13107;
        c    = fx(-65);
        d    = fx(8);
        v_th = fx(30);
        dt   = '0;
        applyReset(fx(-65), '0);
        checkOutput("rst_ready", N'(step_ready), 32'd1);
        checkOutput("rst_done", N'(step_done), 32'd0);
        checkOutput("rst_spikes", N'(spike_vec), 32'd0);
        checkOutput("rst_rd_v", rd_voltage, 32'd0);
        checkOutput("rst_rd_w", rd_w, 32'd0);
        readNeuron(0, fx(-65), '0, "init_n0");
        applyStimulus(8'h00, "dt0_step");
        readNeuron(2, fx(-65), '0, "dt0_n2");
        readNeuron(7, fx(-65), '0, "dt0_n7");

        // Scenario 4: step_valid held high gives back-to-back steps 3*NEURONS+2 apart.
        applyHeldSteps();
        readNeuron(5, fx(-65), '0, "held_n5");

        // Scenario 2: constant drive of 140 per step, then all neurons spike.
        a    = '0;
        dt   = fx(1);
        v_th = fx(30);
        applyReset('0, '0);
        applyStimulus(8'h00, "drive_s1");
        readNeuron(0, 32'sh008C0000, '0, "drive_s1_n0");
        readNeuron(4, fx(140), '0, "drive_s1_n4");
        readNeuron(7, fx(140), '0, "drive_s1_n7");
        applyStimulus(8'hFF, "drive_s2");
        readNeuron(1, fx(-65), fx(8), "drive_s2_n1");
        readNeuron(6, fx(-65), fx(8), "drive_s2_n6");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("spike_hold", N'(spike_vec), 32'h000000FF);

        // Full update with a, b, w and a written current: v=4.0, w=2.0, a=0.5, b=0.25, dt=0.5.
        a    = 32'sd32768;
        b    = 32'sd16384;
        dt   = 32'sd32768;
        v_th = fx(30);
        applyReset(fx(4), fx(2));
        writeCurrent(5, fx(10));
        applyStimulus(8'h00, "full");
        readNeuron(0, 32'sd5460456, 32'sd114688, "full_n0");
        readNeuron(5, 32'sd5788136, 32'sd114688, "full_n5");

        // Scenario 3: only neuron 3 is driven past a threshold of 200.0.
        a    = '0;
        dt   = fx(1);
        v_th = fx(200);
        applyReset('0, '0);
        writeCurrent(3, fx(100));
        applyStimulus(8'h00, "single_s1");
        readNeuron(3, fx(240), '0, "single_s1_n3");
        readNeuron(2, fx(140), '0, "single_s1_n2");
        applyStimulus(8'b0000_1000, "single_s2");
        readNeuron(3, fx(-65), fx(8), "single_s2_n3");
        readNeuron(0, 32'sd115596880, '0, "single_s2_n0");

        // Scenario 5: reset in cycle 5 of a step aborts it with no step_done.
        applyReset('0, '0);
        waitReady();
        step_valid = 1'b1;
        @(posedge clk);
        #1;
        step_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst    = 1'b1;
        v_init = fx(-70);
        w_init = fx(1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_spikes", N'(spike_vec), 32'd0);
        checkOutput("abort_ready", N'(step_ready), 32'd1);
        readNeuron(0, fx(-70), fx(1), "abort_n0");
        readNeuron(7, fx(-70), fx(1), "abort_n7");
        repeat (40) @(posedge clk);
        #1;

`ifdef IZH_REFRACTORY_EN
        // Scenario 6: two refractory steps hold v at c with no spike, then normal rules resume.
        a    = '0;
        dt   = fx(1);
        v_th = fx(30);
        c    = fx(-65);
        d    = fx(8);
        applyReset('0, '0);
        applyStimulus(8'h00, "ref_s1");
        applyStimulus(8'hFF, "ref_s2");
        v_th = fx(-100);
        applyStimulus(8'h00, "ref_s3");
        readNeuron(2, fx(-65), fx(8), "ref_s3_n2");
        applyStimulus(8'h00, "ref_s4");
        readNeuron(2, fx(-65), fx(8), "ref_s4_n2");
        applyStimulus(8'hFF, "ref_s5");
        readNeuron(2, fx(-65), fx(16), "ref_s5_n2");
`endif

        repeat (3) @(posedge clk);
        #1;
        checkOutput("steps_outstanding", N'(step_q.size()), 32'd0);
        checkOutput("reads_outstanding", N'(rd_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
